// File: rtl/fft_pkg.sv
// Shared definitions for the FFT bit-reversal reorder stage: default
// geometry, controller state encoding and the index bit-reversal helper.
package fft_pkg;

    localparam int unsigned DEF_LGSIZE = 12;
    localparam int unsigned DEF_WIDTH  = 16;

    // IDLE: waiting for first sync; FILL: one bank being filled, no
    // output yet; RUN: previous frame complete and streaming out.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } bitrev_state_t;

    // Reverse the low lg bits of v. With a constant lg this reduces to
    // a pure wire permutation.
    function automatic int unsigned bitrev(input int unsigned v, input int unsigned lg);
        int unsigned r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < lg) begin
                r[5'(lg - 1 - i)] = v[5'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_if.sv
// Sample stream bundle between the FFT core and the reorder stage.
interface fft_bitrev_if import fft_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic               i_ce;
    logic               i_sync;
    logic [2*WIDTH-1:0] i_in;
    logic [2*WIDTH-1:0] o_out;
    logic               o_sync;

    modport master (
        output i_ce,
        output i_sync,
        output i_in,
        input  o_out,
        input  o_sync
    );

    modport slave (
        input  i_ce,
        input  i_sync,
        input  i_in,
        output o_out,
        output o_sync
    );

endinterface

// File: rtl/fft_bitrev_mem.sv
// Simple dual-port RAM: one synchronous write port and one registered,
// enable-gated read port. Contents are not reset.
module fft_bitrev_mem import fft_pkg::*; #(
    parameter int unsigned AW = DEF_LGSIZE + 1,
    parameter int unsigned DW = 2 * DEF_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [DW-1:0] r_rdata;

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port, advancing only on enabled cycles.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_bitrev.sv
// Bit-reversal reorder stage: takes the FFT output stream in bit-reversed
// order and emits each frame in natural order one frame later, using a
// double-buffered memory so throughput stays one sample per i_ce.
module fft_bitrev import fft_pkg::*; #(
    parameter int unsigned LGSIZE = DEF_LGSIZE,
    parameter int unsigned WIDTH  = DEF_WIDTH
) (
    input  logic         i_clk,
    input  logic         i_areset_n,
    fft_bitrev_if.slave  bus
);

    localparam int unsigned DW = 2 * WIDTH;

    bitrev_state_t     r_state;
    logic [LGSIZE:0]   r_wraddr;
    logic              r_sync;
    logic              r_out_en;

    logic [LGSIZE-1:0] w_j;
    logic [LGSIZE-1:0] w_j_rev;
    logic              w_bank;
    logic              w_last;
    logic              w_start;
    logic              w_misalign;
    logic              w_we;
    logic [LGSIZE:0]   w_waddr;
    logic [LGSIZE:0]   w_raddr;
    logic [DW-1:0]     w_rdata;

    assign w_j        = r_wraddr[LGSIZE-1:0];
    assign w_bank     = r_wraddr[LGSIZE];
    assign w_last     = (w_j == '1);
    assign w_start    = bus.i_ce && bus.i_sync && (r_state == ST_IDLE);
    assign w_misalign = bus.i_ce && bus.i_sync && (r_state != ST_IDLE) && (w_j != '0);
    assign w_we       = bus.i_ce && ((r_state != ST_IDLE) || bus.i_sync);

    // A sync sample always lands at index 0 of the bank being written,
    // whether it starts the first frame or realigns a broken one.
    assign w_waddr    = (w_start || w_misalign) ? {w_bank, {LGSIZE{1'b0}}} : r_wraddr;

    // Reads always come from the bank not being written.
    assign w_j_rev    = LGSIZE'(bitrev(32'(w_j), LGSIZE));
    assign w_raddr    = {~w_bank, w_j_rev};

    fft_bitrev_mem #(
        .AW (LGSIZE + 1),
        .DW (DW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (bus.i_in),
        .i_re    (bus.i_ce),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Controller: write counter, frame state, output sync and output enable.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state  <= ST_IDLE;
            r_wraddr <= '0;
            r_sync   <= 1'b0;
            r_out_en <= 1'b0;
        end else if (bus.i_ce) begin
            case (r_state)
                ST_IDLE: begin
                    r_sync   <= 1'b0;
                    r_out_en <= 1'b0;
                    if (bus.i_sync) begin
                        r_state  <= ST_FILL;
                        r_wraddr <= {w_bank, LGSIZE'(1)};
                    end
                end
                default: begin
                    if (w_misalign) begin
                        r_state  <= ST_FILL;
                        r_wraddr <= {w_bank, LGSIZE'(1)};
                        r_sync   <= 1'b0;
                        r_out_en <= 1'b0;
                    end else begin
                        r_wraddr <= r_wraddr + {{LGSIZE{1'b0}}, 1'b1};
                        if (w_last) begin
                            r_state <= ST_RUN;
                        end
                        r_sync   <= (r_state == ST_RUN) && (w_j == '0);
                        r_out_en <= (r_state == ST_RUN);
                    end
                end
            endcase
        end
    end

    // Output is built only from registers; the enable flag clears
    // asynchronously so the data word drops to zero on reset without
    // needing a reset on the RAM read register.
    assign bus.o_out  = r_out_en ? w_rdata : '0;
    assign bus.o_sync = r_sync;

endmodule
